sd_card_cmd_responder: RTL and testbench

//  Card-side end of the SD CMD line. It deserialises 48-bit host command frames, checks them,

---
 rtl/sd_card_cmd_responder_pkg.sv | 28 ++
 rtl/sd_crc7.sv | 23 ++
 rtl/sd_card_cmd_responder.sv | 174 +++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared constants, state encoding and CRC7 step for the card-side CMD responder.
package sd_card_cmd_responder_pkg;

    localparam int SD_CMD_FRAME_LEN = 48;
    localparam int SD_CMD_BODY_LEN  = 40;
    localparam int SD_CMD_CRC_LEN   = 7;

    localparam logic [5:0] SD_CMD0_IDX  = 6'd0;
    localparam logic [5:0] SD_R3_IDX    = 6'h3F;
    localparam logic [6:0] SD_R3_CRC    = 7'h7F;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        CRSP_IDLE,
        CRSP_RECV,
        CRSP_CHECK,
        CRSP_WAIT,
        CRSP_SEND
    } crsp_state_e;

    // One serial step of x^7 + x^3 + 1, MSB-first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear with enable restarts the sum on the current bit.
module sd_crc7
    import sd_card_cmd_responder_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      bit_in,
    output logic [SD_CMD_CRC_LEN-1:0] crc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= enable ? crc7_step(7'h00, bit_in) : 7'h00;
        end else if (enable) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card end of the SD CMD line: receives 48-bit host commands, checks them,
// and returns an R1 or R3 response NCR+2 clocks after the end bit.
module sd_card_cmd_responder
    import sd_card_cmd_responder_pkg::*;
#(
    parameter int         NCR        = 2,
    parameter logic [5:0] ACMD41_IDX = 6'd41
) (
    input  logic        CLK_card,
    input  logic        RESET,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    input  logic [31:0] card_status,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        busy
);

    crsp_state_e state;
    crsp_state_e state_nxt;

    logic [SD_CMD_FRAME_LEN-1:0] rx_sr;
    logic [SD_CMD_BODY_LEN-1:0]  tx_sr;
    logic [5:0]                  bit_cnt;
    logic [6:0]                  wait_cnt;
    logic [5:0]                  send_cnt;
    logic                        tx_r3;
    logic                        tx_bit;

    logic [6:0] rx_crc;
    logic [6:0] tx_crc;
    logic       rx_crc_en;
    logic       tx_crc_en;

    logic [5:0]  rx_idx;
    logic [31:0] rx_arg;
    logic        frame_ok;

    assign rx_idx = rx_sr[45:40];
    assign rx_arg = rx_sr[39:8];

    assign frame_ok = !rx_sr[47] && rx_sr[46] && rx_sr[0]
                      && (rx_sr[7:1] == rx_crc);

    assign cmd_valid = (state == CRSP_CHECK) && frame_ok;
    assign crc_err   = (state == CRSP_CHECK) && !frame_ok;
    assign busy      = (state != CRSP_IDLE);

    // The start bit is folded into the CRC on the IDLE->RECV edge.
    assign rx_crc_en = ((state == CRSP_IDLE) && !cmd_in)
                       || ((state == CRSP_RECV)
                           && (bit_cnt < 6'(SD_CMD_BODY_LEN)));

    assign tx_crc_en = (state == CRSP_SEND)
                       && (send_cnt < 6'(SD_CMD_BODY_LEN));

    sd_crc7 u_rx_crc (
        .clk    (CLK_card),
        .reset  (RESET),
        .clear  (state == CRSP_IDLE),
        .enable (rx_crc_en),
        .bit_in (cmd_in),
        .crc    (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .clk    (CLK_card),
        .reset  (RESET),
        .clear  (state != CRSP_SEND),
        .enable (tx_crc_en),
        .bit_in (tx_bit),
        .crc    (tx_crc)
    );

    // Body bits first, then the CRC MSB-first, then the end bit.
    always_comb begin
        tx_bit = 1'b1;
        if (send_cnt < 6'(SD_CMD_BODY_LEN)) begin
            tx_bit = tx_sr[SD_CMD_BODY_LEN-1];
        end else if (send_cnt < 6'(SD_CMD_FRAME_LEN - 1)) begin
            tx_bit = tx_r3 ? SD_R3_CRC[0] : tx_crc[3'(6'd46 - send_cnt)];
        end
    end

    always_ff @(posedge CLK_card) begin
        if (RESET) begin
            state <= CRSP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CRSP_IDLE: begin
                if (!cmd_in) state_nxt = CRSP_RECV;
            end
            CRSP_RECV: begin
                if (bit_cnt == 6'(SD_CMD_FRAME_LEN - 1)) state_nxt = CRSP_CHECK;
            end
            CRSP_CHECK: begin
                if (!frame_ok || rx_idx == SD_CMD0_IDX) begin
                    state_nxt = CRSP_IDLE;
                end else begin
                    state_nxt = CRSP_WAIT;
                end
            end
            CRSP_WAIT: begin
                if (wait_cnt == 7'(NCR - 1)) state_nxt = CRSP_SEND;
            end
            CRSP_SEND: begin
                if (send_cnt == 6'(SD_CMD_FRAME_LEN - 1)) state_nxt = CRSP_IDLE;
            end
            default: state_nxt = CRSP_IDLE;
        endcase
    end

    always_ff @(posedge CLK_card) begin
        if (RESET) begin
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            send_cnt  <= '0;
            tx_r3     <= 1'b0;
            cmd_index <= '0;
            cmd_arg   <= '0;
            cmd_out   <= 1'b1;
            cmd_oe    <= 1'b0;
        end else begin
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
            unique case (state)
                CRSP_IDLE: begin
                    rx_sr   <= {rx_sr[SD_CMD_FRAME_LEN-2:0], cmd_in};
                    bit_cnt <= 6'd1;
                end
                CRSP_RECV: begin
                    rx_sr   <= {rx_sr[SD_CMD_FRAME_LEN-2:0], cmd_in};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                CRSP_CHECK: begin
                    wait_cnt <= '0;
                    if (frame_ok) begin
                        cmd_index <= rx_idx;
                        cmd_arg   <= rx_arg;
                        tx_r3     <= (rx_idx == ACMD41_IDX);
                        tx_sr     <= {2'b00,
                                      (rx_idx == ACMD41_IDX) ? SD_R3_IDX : rx_idx,
                                      card_status};
                    end
                end
                CRSP_WAIT: begin
                    wait_cnt <= wait_cnt + 7'd1;
                    send_cnt <= '0;
                end
                CRSP_SEND: begin
                    cmd_oe   <= 1'b1;
                    cmd_out  <= tx_bit;
                    send_cnt <= send_cnt + 6'd1;
                    if (send_cnt < 6'(SD_CMD_BODY_LEN)) begin
                        tx_sr <= {tx_sr[SD_CMD_BODY_LEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder with NCR=2 and NCR=64 instances.
module tb_sd_card_cmd_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_in;
    logic        cmd_in64;
    logic [31:0] card_status;

    logic        cmd_out, cmd_oe, cmd_valid, crc_err, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    logic        out64, oe64, valid64, err64, busy64;
    logic [5:0]  idx64;
    logic [31:0] arg64;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    logic [47:0] rsp_q[$];

    always #5 clk = ~clk;

    sd_card_cmd_responder #(.NCR(2), .ACMD41_IDX(6'd41)) dut (
        .CLK_card    (clk),
        .RESET       (rst),
        .cmd_in      (cmd_in),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .card_status (card_status),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .crc_err     (crc_err),
        .busy        (busy)
    );

    sd_card_cmd_responder #(.NCR(64), .ACMD41_IDX(6'd41)) dut64 (
        .CLK_card    (clk),
        .RESET       (rst),
        .cmd_in      (cmd_in64),
        .cmd_out     (out64),
        .cmd_oe      (oe64),
        .card_status (card_status),
        .cmd_valid   (valid64),
        .cmd_index   (idx64),
        .cmd_arg     (arg64),
        .crc_err     (err64),
        .busy        (busy64)
    );

    always @(negedge clk) begin
        if (cmd_valid) valid_cnt++;
        if (crc_err) err_cnt++;
    end

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] mk_r1(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, crc7_model({2'b00, idx, st}), 1'b1};
    endfunction

    task automatic send_frame(input bit sel, input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            if (sel) cmd_in64 = f[i];
            else cmd_in = f[i];
        end
        @(negedge clk);
        cmd_in = 1'b1;
        cmd_in64 = 1'b1;
    endtask

    task automatic capture(input bit sel, output int gap, output logic [47:0] rsp,
                           output bit got, output bit held, output bit dropped);
        gap = 0;
        got = 0;
        held = 1;
        dropped = 0;
        rsp = '0;
        while (!(sel ? oe64 : cmd_oe) && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        if (sel ? oe64 : cmd_oe) begin
            got = 1;
            for (int i = 47; i >= 0; i--) begin
                if (!(sel ? oe64 : cmd_oe)) held = 0;
                rsp[i] = sel ? out64 : cmd_out;
                if (i > 0) @(negedge clk);
            end
            @(negedge clk);
            dropped = !(sel ? oe64 : cmd_oe) && ((sel ? out64 : cmd_out) === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_in = 1'b1;
        cmd_in64 = 1'b1;
        card_status = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_out, cmd_oe, cmd_valid, crc_err, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {cmd_out, cmd_oe, cmd_valid, crc_err, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs got %h/%h want 00/00000000", cmd_index, cmd_arg);
        end
        checks++;
        if ({out64, oe64, valid64, err64, busy64} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ncr64 got %b want 10000",
                     {out64, oe64, valid64, err64, busy64});
        end
    endtask

    task automatic test_cmd0();
        int v0;
        bit seen;
        v0 = valid_cnt;
        send_frame(0, 48'h40_0000_0000_95);
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL cmd0_valid got %b want 1", cmd_valid);
        end
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmd_oe !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL cmd0_no_rsp got oe=1 want oe=0");
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL cmd0_pulses got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (cmd_index !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd0_idx got %h busy %b want 00 busy 0", cmd_index, busy);
        end
    endtask

    task automatic test_ncr_sweep();
        int gap, ncr;
        logic [47:0] rsp, exp;
        bit got, held, dropped;
        for (int s = 0; s < 2; s++) begin
            ncr = (s == 1) ? 64 : 2;
            card_status = 32'h0000_0900;
            rsp_q.push_back(mk_r1(6'd17, 32'h0000_0900));
            send_frame(s[0], 48'h51_0000_0000_55);
            fork
                begin
                    @(negedge clk);
                    card_status = 32'hDEAD_BEEF;
                end
            join_none
            capture(s[0], gap, rsp, got, held, dropped);
            exp = rsp_q.pop_front();
            checks++;
            if (!got || gap != ncr + 2) begin
                errors++;
                $display("FAIL gap_ncr%0d got %0d want %0d", ncr, gap, ncr + 2);
            end
            checks++;
            if (rsp !== exp) begin
                errors++;
                $display("FAIL r1_cmd17_ncr%0d got %h want %h", ncr, rsp, exp);
            end
            checks++;
            if (!held || !dropped) begin
                errors++;
                $display("FAIL oe_shape_ncr%0d got held=%b drop=%b want 1/1", ncr, held, dropped);
            end
            checks++;
            if ((s == 1 ? idx64 : cmd_index) !== 6'd17) begin
                errors++;
                $display("FAIL idx17_ncr%0d got %h want 11", ncr, s == 1 ? idx64 : cmd_index);
            end
        end
    endtask

    task automatic test_cmd8();
        int gap;
        logic [47:0] rsp, exp;
        bit got, held, dropped;
        card_status = 32'h0000_0120;
        rsp_q.push_back(mk_r1(6'd8, 32'h0000_0120));
        send_frame(0, 48'h48_0000_01AA_87);
        capture(0, gap, rsp, got, held, dropped);
        exp = rsp_q.pop_front();
        checks++;
        if (!got || rsp !== exp) begin
            errors++;
            $display("FAIL r1_cmd8 got %h want %h", rsp, exp);
        end
        checks++;
        if (cmd_index !== 6'd8 || cmd_arg !== 32'h0000_01AA) begin
            errors++;
            $display("FAIL cmd8_latch got %h/%h want 08/000001aa", cmd_index, cmd_arg);
        end
    endtask

    task automatic test_acmd41();
        int gap;
        logic [47:0] rsp, exp;
        bit got, held, dropped;
        card_status = 32'h0000_0120;
        rsp_q.push_back(mk_r1(6'd55, 32'h0000_0120));
        send_frame(0, 48'h77_0000_0000_65);
        capture(0, gap, rsp, got, held, dropped);
        exp = rsp_q.pop_front();
        checks++;
        if (!got || rsp !== exp) begin
            errors++;
            $display("FAIL r1_cmd55 got %h want %h", rsp, exp);
        end
        card_status = 32'h80FF_8000;
        rsp_q.push_back({8'h3F, 32'h80FF_8000, 8'hFF});
        send_frame(0, mk_frame(6'd41, 32'h4030_0000));
        capture(0, gap, rsp, got, held, dropped);
        exp = rsp_q.pop_front();
        checks++;
        if (!got || rsp !== exp) begin
            errors++;
            $display("FAIL r3_acmd41 got %h want %h", rsp, exp);
        end
        checks++;
        if (cmd_index !== 6'd41 || cmd_arg !== 32'h4030_0000) begin
            errors++;
            $display("FAIL acmd41_latch got %h/%h want 29/40300000", cmd_index, cmd_arg);
        end
    endtask

    task automatic test_crc_err();
        logic [47:0] bad[3];
        int e0, v0;
        bit seen;
        bad[0] = 48'h51_0000_0000_55 ^ 48'h2;
        bad[1] = 48'h51_0000_0000_55 ^ 48'h1;
        bad[2] = {2'b00, 6'd17, 32'h0, crc7_model({2'b00, 6'd17, 32'h0}), 1'b1};
        for (int k = 0; k < 3; k++) begin
            e0 = err_cnt;
            v0 = valid_cnt;
            send_frame(0, bad[k]);
            checks++;
            if (crc_err !== 1'b1 || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL bad%0d_pulse got err=%b valid=%b want 1/0", k, crc_err, cmd_valid);
            end
            seen = 0;
            repeat (60) begin
                @(negedge clk);
                if (cmd_oe !== 1'b0) seen = 1;
            end
            checks++;
            if (seen || err_cnt - e0 != 1 || valid_cnt != v0) begin
                errors++;
                $display("FAIL bad%0d_after got oe=%b errs=%0d valids=%0d want 0/1/0",
                         k, seen, err_cnt - e0, valid_cnt - v0);
            end
            checks++;
            if (cmd_index !== 6'd41 || cmd_arg !== 32'h4030_0000) begin
                errors++;
                $display("FAIL bad%0d_hold got %h/%h want 29/40300000", k, cmd_index, cmd_arg);
            end
        end
    endtask

    task automatic test_send_end_window();
        int gap;
        card_status = 32'h0000_0900;
        send_frame(0, 48'h51_0000_0000_55);
        gap = 0;
        while (!cmd_oe && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        repeat (46) @(negedge clk);
        cmd_in = 1'b0;
        @(negedge clk);
        cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (gap >= 50 || busy !== 1'b0 || cmd_oe !== 1'b0) begin
            errors++;
            $display("FAIL send_end_low got busy=%b oe=%b gap=%0d want 0/0", busy, cmd_oe, gap);
        end
    endtask

    task automatic test_back_to_back();
        int gap, v0;
        logic [47:0] rsp, exp;
        bit got, held, dropped;
        v0 = valid_cnt;
        card_status = 32'h0000_0B00;
        rsp_q.push_back(mk_r1(6'd55, 32'h0000_0B00));
        send_frame(0, 48'h40_0000_0000_95);
        send_frame(0, 48'h77_0000_0000_65);
        capture(0, gap, rsp, got, held, dropped);
        exp = rsp_q.pop_front();
        checks++;
        if (!got || rsp !== exp || valid_cnt - v0 != 2) begin
            errors++;
            $display("FAIL b2b got %h valids=%0d want %h valids=2", rsp, valid_cnt - v0, exp);
        end
    endtask

    task automatic test_reset_mid_send();
        int gap;
        card_status = 32'h0000_0900;
        send_frame(0, 48'h51_0000_0000_55);
        gap = 0;
        while (!cmd_oe && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_oe, cmd_out, busy, cmd_valid, crc_err} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_reset got %b want 01000",
                     {cmd_oe, cmd_out, busy, cmd_valid, crc_err});
        end
        checks++;
        if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_regs got %h/%h want 00/00000000", cmd_index, cmd_arg);
        end
        rst = 1'b0;
        send_frame(0, 48'h40_0000_0000_95);
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_cmd0 got %b want 1", cmd_valid);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_oe !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b oe=%b want 0/0", busy, cmd_oe);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_ncr_sweep();
        test_cmd8();
        test_acmd41();
        test_crc_err();
        test_send_end_window();
        test_back_to_back();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
